// File: rtl/router_input_port.sv
// router_input_port: mesh-router input port; flit FIFO, XY route from head flit, hold-until-release request to output arbiters.
// Ports:
//   clk, rst                 clock, async active-high reset
//   in_valid/in_flit/in_ready   upstream flit interface into the FIFO
//   req0..req4 / gnt0..gnt4     request/grant per output port (0 local, 1 N, 2 E, 3 S, 4 W)
//   out_valid/out_flit/out_ready flit presented to the crossbar
//   err                      sticky: a non-head flit reached the FIFO head while idle
module router_input_port #(
   parameter int DEPTH  = 4,
   parameter int DATA_W = 16,
   parameter int X_W    = 2,
   parameter int Y_W    = 2,
   parameter int MY_X   = 0,
   parameter int MY_Y   = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_flit,
   output logic              in_ready,
   output logic              req0,
   output logic              req1,
   output logic              req2,
   output logic              req3,
   output logic              req4,
   input  logic              gnt0,
   input  logic              gnt1,
   input  logic              gnt2,
   input  logic              gnt3,
   input  logic              gnt4,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_flit,
   input  logic              out_ready,
   output logic              err
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [X_W-1:0] MX = X_W'(MY_X);
   localparam logic [Y_W-1:0] MY = Y_W'(MY_Y);
   typedef enum logic [1:0] {IDLE, ACTIVE, RELEASE} state_t;
   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] mem_d [DEPTH];
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     count_q, count_d;
   state_t            state_q, state_d;
   logic [2:0]        port_q, port_d;
   logic              err_q, err_d;
   logic [DATA_W-1:0] head;
   logic [X_W-1:0]    dx;
   logic [Y_W-1:0]    dy;
   logic [2:0]        route;
   logic [4:0]        gnt, req;
   logic              empty, is_head, is_tail, push, pop, xfer, discard;
   assign gnt      = {gnt4, gnt3, gnt2, gnt1, gnt0};
   assign head     = mem_q[rd_ptr_q];
   assign empty    = (count_q == '0);
   // type 01 head, 11 single: bit 0 marks a head; 10 tail, 11 single: bit 1 marks a tail
   assign is_head  = head[DATA_W-2];
   assign is_tail  = head[DATA_W-1];
   assign dx       = head[X_W+Y_W-1:Y_W];
   assign dy       = head[Y_W-1:0];
   assign route    = (dx > MX) ? 3'd2 : (dx < MX) ? 3'd4 : (dy > MY) ? 3'd1 : (dy < MY) ? 3'd3 : 3'd0;
   // in_ready looks only at the registered count, so a same-cycle pop never frees a slot early
   assign in_ready  = (count_q != CW'(DEPTH));
   assign push      = in_valid & in_ready;
   assign out_valid = (state_q == ACTIVE) & gnt[port_q] & ~empty;
   assign xfer      = out_valid & out_ready;
   assign discard   = (state_q == IDLE) & ~empty & ~is_head;
   assign pop       = xfer | discard;
   assign out_flit  = head;
   assign req       = (state_q == ACTIVE) ? (5'd1 << port_q) : 5'd0;
   assign {req4, req3, req2, req1, req0} = req;
   assign err       = err_q;
   always_comb begin
      mem_d = mem_q;
      if (push) mem_d[wr_ptr_q] = in_flit;
      wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
      count_d  = count_q + CW'(push) - CW'(pop);
   end
   always_comb begin
      state_d = state_q;
      port_d  = port_q;
      err_d   = err_q | discard;
      unique case (state_q)
         IDLE: begin
            if (!empty && is_head) begin
               port_d  = route;
               state_d = ACTIVE;
            end
         end
         ACTIVE:  state_d = (xfer && is_tail) ? RELEASE : ACTIVE;
         RELEASE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_q    <= '{default: '0};
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         state_q  <= IDLE;
         port_q   <= '0;
         err_q    <= 1'b0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         state_q  <= state_d;
         port_q   <= port_d;
         err_q    <= err_d;
      end
   end
endmodule

// File: tb/tb_router_input_port.sv
// tb_router_input_port: directed bench for router_input_port at router (1,1).
module tb_router_input_port;
  logic        clk = 0, rst = 1, in_valid = 0, out_ready = 0;
  logic [15:0] in_flit = '0;
  logic [4:0]  gnt = '0;
  logic [4:0]  req;
  logic        in_ready, out_valid, err;
  logic [15:0] out_flit;
  int          n_chk = 0, n_fail = 0;
  router_input_port #(.DEPTH(4), .DATA_W(16), .X_W(2), .Y_W(2), .MY_X(1), .MY_Y(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_flit(in_flit), .in_ready(in_ready),
    .req0(req[0]), .req1(req[1]), .req2(req[2]), .req3(req[3]), .req4(req[4]),
    .gnt0(gnt[0]), .gnt1(gnt[1]), .gnt2(gnt[2]), .gnt3(gnt[3]), .gnt4(gnt[4]),
    .out_valid(out_valid), .out_flit(out_flit), .out_ready(out_ready), .err(err)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    #100000;
    n_fail++;
    $error("FAIL timeout: test did not finish in time");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
  initial begin
    #2;
    n_chk++;
    if (in_ready !== 1'b1 || req !== 5'b0 || out_valid !== 1'b0 || err !== 1'b0) begin
      n_fail++;
      $error("FAIL reset state: in_ready=%0b req=%0b out_valid=%0b err=%0b", in_ready, req, out_valid, err);
    end
    n_chk++; if (in_ready !== 1'b1) begin n_fail++; $error("FAIL rst_in_ready: %0h", in_ready); end
    n_chk++; if (req !== 5'b0) begin n_fail++; $error("FAIL rst_req: %0h", req); end
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $error("FAIL rst_out_valid: %0h", out_valid); end
    n_chk++; if (err !== 1'b0) begin n_fail++; $error("FAIL rst_err: %0h", err); end
    tick();
    rst = 0;
    tick(); in_valid = 1; in_flit = 16'hC0A5; out_ready = 1; #1;
    tick(); in_valid = 0; #1;
    n_chk++; if (req !== 5'b00000) begin n_fail++; $error("FAIL t1_req_e0: %0h", req); end
    tick(); #1;
    n_chk++; if (req !== 5'b00001) begin n_fail++; $error("FAIL t1_req_e1: %0h", req); end
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $error("FAIL t1_ov_e1: %0h", out_valid); end
    tick(); gnt = 5'b00001; #1;
    n_chk++; if (out_valid !== 1'b1) begin n_fail++; $error("FAIL t1_ov_e2: %0h", out_valid); end
    n_chk++; if (out_flit !== 16'hC0A5) begin n_fail++; $error("FAIL t1_flit: %0h", out_flit); end
    n_chk++; if (req !== 5'b00001) begin n_fail++; $error("FAIL t1_req_e2: %0h", req); end
    tick(); #1;
    n_chk++; if (req !== 5'b00000) begin n_fail++; $error("FAIL t1_rel_req: %0h", req); end
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $error("FAIL t1_rel_ov: %0h", out_valid); end
    tick(); gnt = 0; #1;
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $error("FAIL t1_idle_ov: %0h", out_valid); end
    tick(); in_valid = 1; in_flit = 16'h401D; #1;
    tick(); in_flit = 16'h0222; #1;
    tick(); in_flit = 16'h8333; #1;
    n_chk++; if (req !== 5'b00100) begin n_fail++; $error("FAIL t2_req_on: %0h", req); end
    tick(); in_valid = 0; #1;
    for (int i = 0; i < 5; i++) begin
      tick(); #1;
      n_chk++; if (req !== 5'b00100) begin n_fail++; $error("FAIL t2_hold_req: %0h", req); end
      n_chk++; if (out_valid !== 1'b0) begin n_fail++; $error("FAIL t2_hold_ov: %0h", out_valid); end
    end
    tick(); gnt = 5'b00100; #1;
    n_chk++; if (out_flit !== 16'h401D) begin n_fail++; $error("FAIL t2_head: %0h", out_flit); end
    n_chk++; if (out_valid !== 1'b1) begin n_fail++; $error("FAIL t2_head_ov: %0h", out_valid); end
    tick(); #1;
    n_chk++; if (out_flit !== 16'h0222) begin n_fail++; $error("FAIL t2_body: %0h", out_flit); end
    n_chk++; if (out_valid !== 1'b1) begin n_fail++; $error("FAIL t2_body_ov: %0h", out_valid); end
    tick(); #1;
    n_chk++; if (out_flit !== 16'h8333) begin n_fail++; $error("FAIL t2_tail: %0h", out_flit); end
    n_chk++; if (req !== 5'b00100) begin n_fail++; $error("FAIL t2_tail_req: %0h", req); end
    tick(); #1;
    n_chk++; if (req !== 5'b00000) begin n_fail++; $error("FAIL t2_rel_req: %0h", req); end
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $error("FAIL t2_rel_ov: %0h", out_valid); end
    tick(); gnt = 0; #1;
    tick(); in_valid = 1; in_flit = 16'h401D; #1;
    tick(); in_flit = 16'h0222; #1;
    tick(); in_flit = 16'h8333; #1;
    tick(); in_valid = 0; gnt = 5'b00100; #1;
    n_chk++; if (out_flit !== 16'h401D) begin n_fail++; $error("FAIL t3_head: %0h", out_flit); end
    tick(); out_ready = 0; #1;
    n_chk++; if (out_flit !== 16'h0222) begin n_fail++; $error("FAIL t3_stall1: %0h", out_flit); end
    n_chk++; if (req !== 5'b00100) begin n_fail++; $error("FAIL t3_stall1_req: %0h", req); end
    tick(); #1;
    n_chk++; if (out_flit !== 16'h0222) begin n_fail++; $error("FAIL t3_stall2: %0h", out_flit); end
    n_chk++; if (out_valid !== 1'b1) begin n_fail++; $error("FAIL t3_stall2_ov: %0h", out_valid); end
    tick(); out_ready = 1; #1;
    n_chk++; if (out_flit !== 16'h0222) begin n_fail++; $error("FAIL t3_body: %0h", out_flit); end
    tick(); #1;
    n_chk++; if (out_flit !== 16'h8333) begin n_fail++; $error("FAIL t3_tail: %0h", out_flit); end
    n_chk++; if (out_valid !== 1'b1) begin n_fail++; $error("FAIL t3_tail_ov: %0h", out_valid); end
    tick(); #1;
    n_chk++; if (req !== 5'b00000) begin n_fail++; $error("FAIL t3_rel_req: %0h", req); end
    tick(); gnt = 0; out_ready = 0; #1;
    tick(); in_valid = 1; in_flit = 16'h4005; #1;
    tick(); in_flit = 16'h0001; #1;
    tick(); in_flit = 16'h0002; #1;
    tick(); in_flit = 16'h8003; #1;
    n_chk++; if (in_ready !== 1'b1) begin n_fail++; $error("FAIL t4_ready_3: %0h", in_ready); end
    tick(); in_flit = 16'h0BAD; #1;
    n_chk++; if (in_ready !== 1'b0) begin n_fail++; $error("FAIL t4_full: %0h", in_ready); end
    tick(); in_valid = 0; gnt = 5'b00001; out_ready = 1; #1;
    n_chk++; if (in_ready !== 1'b0) begin n_fail++; $error("FAIL t4_full2: %0h", in_ready); end
    n_chk++; if (out_flit !== 16'h4005) begin n_fail++; $error("FAIL t4_f0: %0h", out_flit); end
    tick(); #1;
    n_chk++; if (in_ready !== 1'b1) begin n_fail++; $error("FAIL t4_ready_back: %0h", in_ready); end
    n_chk++; if (out_flit !== 16'h0001) begin n_fail++; $error("FAIL t4_f1: %0h", out_flit); end
    tick(); #1;
    n_chk++; if (out_flit !== 16'h0002) begin n_fail++; $error("FAIL t4_f2: %0h", out_flit); end
    tick(); #1;
    n_chk++; if (out_flit !== 16'h8003) begin n_fail++; $error("FAIL t4_f3: %0h", out_flit); end
    n_chk++; if (out_valid !== 1'b1) begin n_fail++; $error("FAIL t4_f3_ov: %0h", out_valid); end
    tick(); #1;
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $error("FAIL t4_empty_ov: %0h", out_valid); end
    n_chk++; if (req !== 5'b00000) begin n_fail++; $error("FAIL t4_rel_req: %0h", req); end
    tick(); gnt = 0; #1;
    tick(); in_valid = 1; in_flit = 16'h0077; #1;
    tick(); in_valid = 0; #1;
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $error("FAIL t5_disc_ov: %0h", out_valid); end
    n_chk++; if (err !== 1'b0) begin n_fail++; $error("FAIL t5_err_pre: %0h", err); end
    tick(); #1;
    n_chk++; if (err !== 1'b1) begin n_fail++; $error("FAIL t5_err: %0h", err); end
    n_chk++; if (req !== 5'b00000) begin n_fail++; $error("FAIL t5_req_none: %0h", req); end
    tick(); in_valid = 1; in_flit = 16'hC011; #1;
    tick(); in_valid = 0; #1;
    tick(); #1;
    n_chk++; if (req !== 5'b10000) begin n_fail++; $error("FAIL t5_req_west: %0h", req); end
    n_chk++; if (err !== 1'b1) begin n_fail++; $error("FAIL t5_err_sticky: %0h", err); end
    tick(); gnt = 5'b10000; #1;
    n_chk++; if (out_flit !== 16'hC011) begin n_fail++; $error("FAIL t5_flit: %0h", out_flit); end
    tick(); #1;
    tick(); gnt = 0; #1;
    tick(); in_valid = 1; in_flit = 16'h4004; #1;
    tick(); in_flit = 16'h0055; #1;
    tick(); in_valid = 0; #1;
    n_chk++; if (req !== 5'b01000) begin n_fail++; $error("FAIL t6_req_south: %0h", req); end
    gnt = 5'b01000; out_ready = 0; #1;
    n_chk++; if (out_valid !== 1'b1) begin n_fail++; $error("FAIL t6_ov_pre: %0h", out_valid); end
    rst = 1; #1;
    n_chk++; if (req !== 5'b00000) begin n_fail++; $error("FAIL t6_rst_req: %0h", req); end
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $error("FAIL t6_rst_ov: %0h", out_valid); end
    n_chk++; if (err !== 1'b0) begin n_fail++; $error("FAIL t6_rst_err: %0h", err); end
    n_chk++; if (in_ready !== 1'b1) begin n_fail++; $error("FAIL t6_rst_ready: %0h", in_ready); end
    tick(); rst = 0; #1;
    tick(); #1;
    n_chk++; if (req !== 5'b00000) begin n_fail++; $error("FAIL t6_idle_req: %0h", req); end
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $error("FAIL t6_idle_ov: %0h", out_valid); end
    tick(); gnt = 0; out_ready = 1; in_valid = 1; in_flit = 16'hC006; #1;
    tick(); in_valid = 0; #1;
    tick(); #1;
    n_chk++; if (req !== 5'b00010) begin n_fail++; $error("FAIL t7_req_north: %0h", req); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
